dram_request_arbiter: RTL and testbench

- Shares the single-requester DRAM read/writeback interface between NUM_REQ cache requesters.
- Each transaction is a 128-bit lane read plus an optional dirty writeback (evict).
- Round-robin grant; sits between the cache/fetch units and the DRAM controller, in the main_clk domain.
- Issues the controller's single-cycle read pulse and holds the granted requester's address and data mux stable until the controller's ack pulse, then routes the ack back.

---
 rtl/dram_arb_pkg.sv | 18 +
 rtl/rr_priority_picker.sv | 30 +++
 rtl/dram_request_arbiter.sv | 159 +++++++++++++++
 tb/tb_dram_request_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared widths, FSM encoding and a small wrap helper for the DRAM request arbiter.
package dram_arb_pkg;

  localparam int ADDR_UPPER_W  = 13;
  localparam int ADDR_COMMON_W = 9;
  localparam int LANE_W        = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    found   = 1'b0;
    index   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos     = (int'(rr_ptr) + k) % NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!found && req[pos_idx]) begin
        found = 1'b1;
        index = pos_idx;
      end
    end
  end

endmodule

// File: rtl/dram_request_arbiter.sv
// Round-robin arbiter sharing the DRAM read/writeback controller port among NUM_REQ requesters.
// Define DRAM_ARB_PERF_EN to add per-requester grant counters and a saturating max-wait register.
//
// state | meaning
// IDLE  | no transaction; choose next requester round-robin and fire the read pulse
// BUSY  | controller owns the granted requester's address/data; waiting for its ack
// DONE  | req_ack pulse to the granted requester; rdata valid
module dram_request_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             main_clk,
  input  logic                             main_rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_UPPER_W-1:0]  req_addr_read_upper,
  input  logic [NUM_REQ*ADDR_UPPER_W-1:0]  req_addr_write_upper,
  input  logic [NUM_REQ*ADDR_COMMON_W-1:0] req_addr_common,
  input  logic [NUM_REQ-1:0]               req_dirty,
  input  logic [NUM_REQ*LANE_W-1:0]        req_wdata,
  output logic [NUM_REQ-1:0]               req_ack,
  output logic [LANE_W-1:0]                rdata,
  output logic [ADDR_UPPER_W-1:0]          ctrl_addr_read,
  output logic [ADDR_UPPER_W-1:0]          ctrl_addr_write,
  output logic [ADDR_COMMON_W-1:0]         ctrl_addr_common,
  output logic [LANE_W-1:0]                ctrl_wdata,
  output logic                             ctrl_dirty,
  output logic                             ctrl_req_pulse,
  input  logic                             ctrl_ack_pulse,
  input  logic [LANE_W-1:0]                ctrl_rdata
`ifdef DRAM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]            perf_grants,
  output logic [15:0]                      perf_max_wait
`endif
);

  localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               req_pulse_q, req_pulse_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .index  (pick_idx)
  );

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      req_pulse_q <= 1'b0;
      req_ack_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      req_pulse_q <= req_pulse_d;
      req_ack_q   <= req_ack_d;
    end
  end

  // Acks outside BUSY fall through untouched: after a mid-transaction reset the
  // controller still finishes and its late ack must not reach any requester.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    req_pulse_d = 1'b0;
    req_ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          rr_ptr_d    = IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
          req_pulse_d = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (ctrl_ack_pulse) begin
          req_ack_d = ACK_ONE << grant_q;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // grant_q only moves in IDLE, so the controller-facing mux is frozen from the
  // read pulse through the ack cycle without extra holding registers.
  always_comb begin
    ctrl_addr_read   = req_addr_read_upper[int'(grant_q)*ADDR_UPPER_W +: ADDR_UPPER_W];
    ctrl_addr_write  = req_addr_write_upper[int'(grant_q)*ADDR_UPPER_W +: ADDR_UPPER_W];
    ctrl_addr_common = req_addr_common[int'(grant_q)*ADDR_COMMON_W +: ADDR_COMMON_W];
    ctrl_wdata       = req_wdata[int'(grant_q)*LANE_W +: LANE_W];
    ctrl_dirty       = req_dirty[grant_q];
  end

  assign ctrl_req_pulse = req_pulse_q;
  assign req_ack        = req_ack_q;
  assign rdata          = ctrl_rdata;

`ifdef DRAM_ARB_PERF_EN
  logic [NUM_REQ*32-1:0] grants_q, grants_d;
  logic [15:0]           wait_q [NUM_REQ];
  logic [15:0]           wait_d [NUM_REQ];
  logic [15:0]           max_wait_q, max_wait_d;

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      grants_q   <= '0;
      max_wait_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      grants_q   <= grants_d;
      max_wait_q <= max_wait_d;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  // wait_q[i] holds cycles since req_valid[i] rose; it is sampled in the ack cycle
  // and restarts there so a requester that keeps valid high is timed afresh.
  always_comb begin
    grants_d   = grants_q;
    max_wait_d = max_wait_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_valid[i] || req_ack_q[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != 16'hFFFF) begin
        wait_d[i] = wait_q[i] + 16'd1;
      end else begin
        wait_d[i] = wait_q[i];
      end
      if (req_ack_q[i] && (wait_q[i] > max_wait_d)) max_wait_d = wait_q[i];
    end
    if ((state_q == IDLE) && pick_found) begin
      grants_d[int'(pick_idx)*32 +: 32] = grants_q[int'(pick_idx)*32 +: 32] + 32'd1;
    end
  end

  assign perf_grants   = grants_q;
  assign perf_max_wait = max_wait_q;
`endif

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Self-checking bench for dram_request_arbiter (NUM_REQ=2) with a simple DRAM controller model.
module tb_dram_request_arbiter;

  logic         main_clk = 1'b0;
  logic         main_rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [12:0]  rd_up [2];
  logic [12:0]  wr_up [2];
  logic [8:0]   com   [2];
  logic         dirt  [2];
  logic [127:0] wd    [2];
  logic [25:0]  req_addr_read_upper, req_addr_write_upper;
  logic [17:0]  req_addr_common;
  logic [1:0]   req_dirty;
  logic [255:0] req_wdata;
  logic [1:0]   req_ack;
  logic [127:0] rdata, ctrl_wdata;
  logic [12:0]  ctrl_addr_read, ctrl_addr_write;
  logic [8:0]   ctrl_addr_common;
  logic         ctrl_dirty, ctrl_req_pulse;
  logic         ctrl_ack_pulse = 1'b0;
  logic [127:0] ctrl_rdata = '0;
`ifdef DRAM_ARB_PERF_EN
  logic [63:0]  perf_grants;
  logic [15:0]  perf_max_wait;
`endif

  assign req_addr_read_upper  = {rd_up[1], rd_up[0]};
  assign req_addr_write_upper = {wr_up[1], wr_up[0]};
  assign req_addr_common      = {com[1], com[0]};
  assign req_dirty            = {dirt[1], dirt[0]};
  assign req_wdata            = {wd[1], wd[0]};

  dram_request_arbiter #(.NUM_REQ(2)) dut (
    .main_clk             (main_clk),
    .main_rst_n           (main_rst_n),
    .req_valid            (req_valid),
    .req_addr_read_upper  (req_addr_read_upper),
    .req_addr_write_upper (req_addr_write_upper),
    .req_addr_common      (req_addr_common),
    .req_dirty            (req_dirty),
    .req_wdata            (req_wdata),
    .req_ack              (req_ack),
    .rdata                (rdata),
    .ctrl_addr_read       (ctrl_addr_read),
    .ctrl_addr_write      (ctrl_addr_write),
    .ctrl_addr_common     (ctrl_addr_common),
    .ctrl_wdata           (ctrl_wdata),
    .ctrl_dirty           (ctrl_dirty),
    .ctrl_req_pulse       (ctrl_req_pulse),
    .ctrl_ack_pulse       (ctrl_ack_pulse),
    .ctrl_rdata           (ctrl_rdata)
`ifdef DRAM_ARB_PERF_EN
    ,
    .perf_grants          (perf_grants),
    .perf_max_wait        (perf_max_wait)
`endif
  );

  always #5 main_clk = ~main_clk;

  int cyc = 0;
  always @(posedge main_clk) cyc <= cyc + 1;

  int ack_events = 0;
  always @(negedge main_clk) if (req_ack != 2'b00) ack_events++;

  // Controller model: acks ack_delay cycles after the pulse and checks the mux is frozen meanwhile.
  int           ack_delay = 16;
  int           pulse_cnt = 0;
  int           ack_cyc = -1;
  bit           stable_ok = 1'b0;
  logic [127:0] model_lane = '0;
  logic [127:0] ack_wdata = '0;
  logic         ack_dirty = 1'b0;
  logic [163:0] cap;
  wire  [163:0] mux_now = {ctrl_addr_read, ctrl_addr_write, ctrl_addr_common, ctrl_dirty, ctrl_wdata};

  always begin
    @(posedge main_clk);
    #1;
    if (ctrl_req_pulse) begin
      cap = mux_now;
      ctrl_rdata = '0;
      pulse_cnt++;
      stable_ok = 1'b1;
      for (int k = 0; k < ack_delay; k++) begin
        @(posedge main_clk);
        #1;
        if (mux_now != cap) stable_ok = 1'b0;
      end
      ctrl_ack_pulse = 1'b1;
      ack_cyc    = cyc;
      ack_wdata  = ctrl_wdata;
      ack_dirty  = ctrl_dirty;
      model_lane = {4{32'hD0A0_0000 + 32'(pulse_cnt)}};
      ctrl_rdata = model_lane;
      @(posedge main_clk);
      #1;
      ctrl_ack_pulse = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge main_clk);
    #2;
  endtask

  task automatic zero_inputs();
    req_valid = '0;
    for (int r = 0; r < 2; r++) begin
      rd_up[r] = '0; wr_up[r] = '0; com[r] = '0; dirt[r] = 1'b0; wd[r] = '0;
    end
  endtask

  task automatic wait_ack(output logic [1:0] a, output int k);
    a = '0;
    k = -1;
    for (int i = 0; i < 100; i++) begin
      if (a == 2'b00) begin
        if (req_ack != 2'b00) begin
          a = req_ack;
          k = cyc;
        end else begin
          step();
        end
      end
    end
  endtask

  task automatic do_reset();
    main_rst_n = 1'b0;
    zero_inputs();
    step();
    step();
    check("reset_outputs", {ctrl_req_pulse, req_ack, ctrl_addr_read, ctrl_addr_write,
                            ctrl_addr_common, ctrl_dirty, ctrl_wdata}, '0);
`ifdef DRAM_ARB_PERF_EN
    check("reset_perf", {perf_grants, perf_max_wait}, '0);
`endif
    main_rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    int           r;
    logic [12:0]  rd;
    logic [12:0]  wr;
    logic [8:0]   cm;
    logic         dirty;
    logic [127:0] wdat;
    logic [1:0]   exp_ack;
    logic [163:0] exp_mux;
    logic [128:0] exp_ackdata;
  } vec_t;

  function automatic vec_t mk(input int r, input logic [12:0] rd, input logic [12:0] wr,
                              input logic [8:0] cm, input logic dirty, input logic [127:0] wdat,
                              input logic [1:0] exp_ack);
    vec_t t;
    t.r = r; t.rd = rd; t.wr = wr; t.cm = cm; t.dirty = dirty; t.wdat = wdat;
    t.exp_ack     = exp_ack;
    t.exp_mux     = {rd, wr, cm, dirty, wdat};
    t.exp_ackdata = {dirty, wdat};
    return t;
  endfunction

  vec_t vecs [4];

  task automatic run_vec(input vec_t t);
    logic [1:0] a;
    int k, p0, o;
    o = 1 - t.r;
    rd_up[t.r] = t.rd; wr_up[t.r] = t.wr; com[t.r] = t.cm; dirt[t.r] = t.dirty; wd[t.r] = t.wdat;
    rd_up[o] = ~t.rd; wr_up[o] = ~t.wr; com[o] = ~t.cm; dirt[o] = ~t.dirty; wd[o] = ~t.wdat;
    p0 = pulse_cnt;
    req_valid[t.r] = 1'b1;
    step();
    check($sformatf("v%0d_pulse_latency", t.r), ctrl_req_pulse, 1'b1);
    check($sformatf("v%0d_mux_select", t.r), mux_now, t.exp_mux);
    wait_ack(a, k);
    check("vec_req_ack", a, t.exp_ack);
    check("vec_ack_latency", k, ack_cyc + 1);
    check("vec_rdata", rdata, model_lane);
    check("vec_mux_stable", stable_ok, 1'b1);
    check("vec_ack_cycle_wdata", {ack_dirty, ack_wdata}, t.exp_ackdata);
    req_valid[t.r] = 1'b0;
    step();
    check("vec_req_ack_single", req_ack, 2'b00);
    check("vec_pulse_count", pulse_cnt - p0, 1);
    step();
  endtask

  logic [1:0] fair_exp [4];
  int         perf_d   [3];

  initial begin
    logic [1:0] a;
    int k, p, ev0, r0, meas, max_meas;

    vecs[0] = mk(0, 13'h00A5, 13'h0000, 9'h1F3, 1'b0, '0, 2'b01);
    vecs[1] = mk(1, 13'h1234, 13'h0ABC, 9'h0F0, 1'b1,
                 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 2'b10);
    vecs[2] = mk(0, 13'h1FFF, 13'h1FFF, 9'h1FF, 1'b1, {128{1'b1}}, 2'b01);
    vecs[3] = mk(1, 13'h0000, 13'h0001, 9'h000, 1'b0, {32{4'h5}}, 2'b10);
    fair_exp[0] = 2'b01; fair_exp[1] = 2'b10; fair_exp[2] = 2'b01; fair_exp[3] = 2'b10;
    perf_d[0] = 16; perf_d[1] = 5; perf_d[2] = 9;

    zero_inputs();
    do_reset();
    ack_delay = 16;
    for (int v = 0; v < 4; v++) run_vec(vecs[v]);

    // Simultaneous requests: 0 first, wdata held until after req0's ack, then requester 1.
    do_reset();
    ack_delay = 6;
    rd_up[0] = 13'h0111; wd[0] = {4{32'hAAAA_0000}};
    rd_up[1] = 13'h0222; wd[1] = {4{32'hBBBB_1111}};
    req_valid = 2'b11;
    step();
    p = cyc;
    check("simul_first_pulse", ctrl_req_pulse, 1'b1);
    check("simul_first_addr", ctrl_addr_read, 13'h0111);
    check("simul_first_wdata", ctrl_wdata, {4{32'hAAAA_0000}});
    wait_ack(a, k);
    check("simul_first_ack", a, 2'b01);
    check("simul_first_stable", stable_ok, 1'b1);
    check("simul_wdata_hold_done", ctrl_wdata, {4{32'hAAAA_0000}});
    req_valid[0] = 1'b0;
    step();
    check("simul_wdata_hold_idle", ctrl_wdata, {4{32'hAAAA_0000}});
    step();
    check("simul_second_pulse", ctrl_req_pulse, 1'b1);
    check("simul_pulse_spacing", cyc - p, 9);
    check("simul_second_wdata", ctrl_wdata, {4{32'hBBBB_1111}});
    wait_ack(a, k);
    check("simul_second_ack", a, 2'b10);
    req_valid[1] = 1'b0;
    step();
    step();

    // Fairness: requester 0 drops and reasserts at once, requester 1 held high.
    do_reset();
    ack_delay = 3;
    rd_up[0] = 13'h0333; rd_up[1] = 13'h0444;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_ack(a, k);
      check($sformatf("fair_grant%0d", g), a, fair_exp[g]);
      if (a == 2'b01) begin
        req_valid[0] = 1'b0;
        step();
        req_valid[0] = 1'b1;
      end else begin
        step();
      end
    end
    req_valid = '0;
    step();
    step();

    // Reset 5 cycles into BUSY; the controller's late ack must be dropped.
    do_reset();
    ack_delay = 16;
    rd_up[0] = 13'h0155; com[0] = 9'h0AA; dirt[0] = 1'b1; wd[0] = {4{32'h1357_9BDF}};
    req_valid = 2'b01;
    step();
    p = cyc;
    check("rst_pulse", ctrl_req_pulse, 1'b1);
    repeat (5) step();
    ev0 = ack_events;
    main_rst_n = 1'b0;
    zero_inputs();
    #1;
    check("rst_outputs_zero", {ctrl_req_pulse, req_ack, ctrl_addr_read, ctrl_addr_write,
                               ctrl_addr_common, ctrl_dirty, ctrl_wdata, rdata}, '0);
    step();
    step();
    main_rst_n = 1'b1;
    repeat (14) step();
    check("rst_stray_ack_cycle", ack_cyc, p + 16);
    check("rst_no_req_ack", ack_events - ev0, 0);
    rd_up[1] = 13'h0AAA;
    req_valid = 2'b10;
    step();
    check("rst_next_pulse", ctrl_req_pulse, 1'b1);
    check("rst_next_addr", ctrl_addr_read, 13'h0AAA);
    wait_ack(a, k);
    check("rst_next_ack", a, 2'b10);
    req_valid = '0;
    step();
    step();

`ifdef DRAM_ARB_PERF_EN
    do_reset();
    max_meas = 0;
    rd_up[1] = 13'h0777;
    for (int i = 0; i < 3; i++) begin
      ack_delay = perf_d[i];
      req_valid[1] = 1'b1;
      r0 = cyc;
      wait_ack(a, k);
      check("perf_ack", a, 2'b10);
      meas = k - r0;
      if (meas > max_meas) max_meas = meas;
      req_valid[1] = 1'b0;
      step();
      step();
    end
    check("perf_grants_req1", perf_grants[63:32], 32'd3);
    check("perf_grants_req0", perf_grants[31:0], 32'd0);
    check("perf_max_wait_measured", perf_max_wait, 16'(max_meas));
    check("perf_max_wait_value", perf_max_wait, 16'd18);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
